// File: rtl/serial_exec_unit.sv
// ============================================================================
//  Module   : serial_exec_unit
//  Brief    : Execute stage with single-cycle ALU ops, bit-serial shifts and
//             branch resolution behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op_res,
    input  logic [2:0]       branch,
    input  logic             is_branch,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SLL  = 4'b0001;
    localparam logic [3:0] c_OP_SLT  = 4'b0010;
    localparam logic [3:0] c_OP_SLTU = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_OR   = 4'b1000;
    localparam logic [3:0] c_OP_AND  = 4'b1001;

    localparam logic [2:0] c_BR_EQ   = 3'b000;
    localparam logic [2:0] c_BR_NE   = 3'b001;
    localparam logic [2:0] c_BR_JAL  = 3'b010;
    localparam logic [2:0] c_BR_LT   = 3'b100;
    localparam logic [2:0] c_BR_GE   = 3'b101;
    localparam logic [2:0] c_BR_LTU  = 3'b110;
    localparam logic [2:0] c_BR_GEU  = 3'b111;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] c_CNT_ONE  = SHAMT_W'(1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_taken;
    logic [WIDTH-1:0]   r_shreg;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_lt_s;
    logic               w_lt_u;
    logic               w_eq;
    logic [WIDTH-1:0]   w_alu;
    logic               w_taken;
    logic               w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_shift_next;

    assign w_sum      = op_a + op_b;
    assign w_diff     = op_a - op_b;
    assign w_lt_s     = $signed(op_a) < $signed(op_b);
    assign w_lt_u     = op_a < op_b;
    assign w_eq       = (op_a == op_b);
    assign w_shamt    = op_b[SHAMT_W-1:0];
    assign w_is_shift = (alu_op_res == c_OP_SLL) || (alu_op_res == c_OP_SRL);

    // Shift codes pass op_a through so a zero shift amount finishes in one cycle.
    always_comb begin
        w_alu = w_sum;
        case (alu_op_res)
            c_OP_ADD:  w_alu = w_sum;
            c_OP_SUB:  w_alu = w_diff;
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt_s};
            c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_lt_u};
            c_OP_XOR:  w_alu = op_a ^ op_b;
            c_OP_OR:   w_alu = op_a | op_b;
            c_OP_AND:  w_alu = op_a & op_b;
            c_OP_SLL:  w_alu = op_a;
            c_OP_SRL:  w_alu = op_a;
            default:   w_alu = w_sum;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (branch)
            c_BR_EQ:  w_taken = w_eq;
            c_BR_NE:  w_taken = !w_eq;
            c_BR_JAL: w_taken = 1'b1;
            c_BR_LT:  w_taken = w_lt_s;
            c_BR_GE:  w_taken = !w_lt_s;
            c_BR_LTU: w_taken = w_lt_u;
            c_BR_GEU: w_taken = !w_lt_u;
            default:  w_taken = 1'b0;
        endcase
        if (!is_branch) begin
            w_taken = 1'b0;
        end
    end

    assign w_shift_next = r_left ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_taken  <= 1'b0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_taken <= w_taken;
                        if (w_is_shift && (w_shamt != c_CNT_ZERO)) begin
                            r_shreg <= op_a;
                            r_cnt   <= w_shamt;
                            r_left  <= (alu_op_res == c_OP_SLL);
                            r_state <= c_SHIFT;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    // The last single-bit step lands directly in the result register.
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == c_IDLE);
    assign out_valid    = (r_state == c_DONE);
    assign result       = r_result;
    assign zero         = r_zero;
    assign branch_taken = r_taken;

endmodule

`default_nettype wire

// File: tb/tb_serial_exec_unit.sv
// ============================================================================
//  Module   : tb_serial_exec_unit
//  Brief    : Self-checking bench for serial_exec_unit (vector table plus
//             reset and backpressure sequences, queue-based scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_exec_unit;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  br;
        logic        isb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        tk;
        int          lat;
    } vec_t;

    localparam int c_NVEC = 24;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op_res;
    logic [2:0]  branch;
    logic        is_branch;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;

    int   checks;
    int   errors;
    vec_t vecs [c_NVEC];
    vec_t exp_q[$];

    serial_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op_res   (alu_op_res),
        .branch       (branch),
        .is_branch    (is_branch),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] br, input logic isb,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic tk, input int lat);
        vec_t v;
        v.op = op; v.br = br; v.isb = isb; v.a = a; v.b = b;
        v.res = res; v.z = (res == 32'd0); v.tk = tk; v.lat = lat;
        return v;
    endfunction

    // Presents one operation, waits for acceptance, then scrambles the inputs.
    task automatic drive(input vec_t v, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        alu_op_res = v.op; branch = v.br; is_branch = v.isb;
        op_a = v.a; op_b = v.b; in_valid = 1'b1;
        if (push) exp_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        alu_op_res = 4'($urandom);
        branch     = 3'($urandom);
        is_branch  = 1'($urandom);
        op_a       = $urandom;
        op_b       = $urandom;
    endtask

    // Counts negedges from the accept edge until out_valid, then scores it.
    task automatic collect();
        int   lat;
        vec_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            if (!out_valid) begin
                check("out_valid_timeout", 32'd0, 32'd1);
            end else begin
                check($sformatf("result op=%0h a=%08h b=%08h", e.op, e.a, e.b), result, e.res);
                check($sformatf("zero op=%0h a=%08h b=%08h", e.op, e.a, e.b), {31'd0, zero}, {31'd0, e.z});
                check($sformatf("taken op=%0h br=%0b isb=%0b", e.op, e.br, e.isb),
                      {31'd0, branch_taken}, {31'd0, e.tk});
                check($sformatf("latency op=%0h b=%08h", e.op, e.b), 32'(lat), 32'(e.lat));
            end
        end
    endtask

    initial begin
        int   seen;
        vec_t v2;
        checks = 0;
        errors = 0;

        //        op     br      isb   a             b             result        tk    lat
        vecs[0]  = mk(4'h0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
        vecs[1]  = mk(4'h6, 3'b000, 1'b0, 32'd5,        32'd5,        32'h00000000, 1'b0, 1);
        vecs[2]  = mk(4'h1, 3'b000, 1'b0, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 4);
        vecs[3]  = mk(4'h5, 3'b000, 1'b0, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 32);
        vecs[4]  = mk(4'h1, 3'b000, 1'b0, 32'hDEADBEEF, 32'h00000040, 32'hDEADBEEF, 1'b0, 1);
        vecs[5]  = mk(4'h2, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
        vecs[6]  = mk(4'h3, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
        vecs[7]  = mk(4'hF, 3'b000, 1'b0, 32'd3,        32'd4,        32'd7,        1'b0, 1);
        vecs[8]  = mk(4'h6, 3'b000, 1'b1, 32'h10,       32'h10,       32'h00000000, 1'b1, 1);
        vecs[9]  = mk(4'h6, 3'b100, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1);
        vecs[10] = mk(4'h6, 3'b110, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1);
        vecs[11] = mk(4'h6, 3'b010, 1'b1, 32'd3,        32'd1,        32'd2,        1'b1, 1);
        vecs[12] = mk(4'h6, 3'b011, 1'b1, 32'd3,        32'd1,        32'd2,        1'b0, 1);
        vecs[13] = mk(4'h6, 3'b000, 1'b0, 32'h10,       32'h10,       32'h00000000, 1'b0, 1);
        vecs[14] = mk(4'h4, 3'b000, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
        vecs[15] = mk(4'h8, 3'b000, 1'b0, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1);
        vecs[16] = mk(4'h9, 3'b000, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1);
        vecs[17] = mk(4'h5, 3'b000, 1'b0, 32'h80000000, 32'd1,        32'h40000000, 1'b0, 2);
        vecs[18] = mk(4'h1, 3'b000, 1'b0, 32'h80000001, 32'd1,        32'h00000002, 1'b0, 2);
        vecs[19] = mk(4'h6, 3'b001, 1'b1, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b1, 1);
        vecs[20] = mk(4'h6, 3'b101, 1'b1, 32'd0,        32'hFFFFFFFF, 32'd1,        1'b1, 1);
        vecs[21] = mk(4'h6, 3'b111, 1'b1, 32'd0,        32'hFFFFFFFF, 32'd1,        1'b0, 1);
        vecs[22] = mk(4'h0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
        vecs[23] = mk(4'h1, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd31,       32'h80000000, 1'b0, 32);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op_res = '0; branch = '0; is_branch = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  {31'd0, in_ready},     32'd1);
        check("reset_out_valid", {31'd0, out_valid},    32'd0);
        check("reset_result",    result,                32'd0);
        check("reset_zero",      {31'd0, zero},         32'd0);
        check("reset_taken",     {31'd0, branch_taken}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i], 1'b1);
            collect();
        end

        // Reset while shifting must discard the operation.
        drive(mk(4'h1, 3'b000, 1'b0, 32'h1, 32'd20, 32'h00100000, 1'b0, 21), 1'b0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midshift_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midshift_reset_result",    result,             32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midshift_no_out_valid", 32'(seen), 32'd0);
        check("midshift_in_ready",     {31'd0, in_ready}, 32'd1);
        check("midshift_result_held",  result, 32'd0);

        // Backpressure: result held, second request blocked until DONE is left.
        out_ready = 1'b0;
        drive(mk(4'h0, 3'b000, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1), 1'b1);
        collect();
        v2 = mk(4'h0, 3'b000, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                alu_op_res = v2.op; branch = v2.br; is_branch = v2.isb;
                op_a = v2.a; op_b = v2.b; in_valid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("bp_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_result_%0d", k),    result,             32'd30);
            check($sformatf("bp_in_ready_%0d", k),  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        exp_q.push_back(v2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_exec_unit.md
Name: serial_exec_unit

Overview:
- Execute stage directly downstream of the ALU control decoder. It consumes the 4-bit ALU operation code and the 3-bit branch code from the decoder, plus register/immediate operands from the datapath.
- Produces the ALU result, a zero flag and a branch-taken decision behind a valid/ready handshake.
- Shifts are executed serially, one bit position per cycle, to save area. All other operations complete in one cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation
- alu_op_res  input  4  ALU operation code from the decoder
- branch  input  3  branch code from the decoder (funct3 for B-type, 010 for JAL)
- is_branch  input  1  1 = branch/jump instruction (alu_op 01 or 11); qualifies branch
- op_a  input  WIDTH  operand A (rs1)
- op_b  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  ALU result
- zero  output  1  result == 0
- branch_taken  output  1  branch/jump decision

Behaviour:
- Op codes (shared defines header values):
  - ADD=0000, SLL/SLLI=0001, SLT=0010, SLTU=0011, XOR=0100, SRL/SRLI=0101, SUB=0110, OR=1000, AND=1001.
  - Any other code executes as ADD.
- Reset (asynchronous, immediate): state=IDLE; result=0, zero=0, branch_taken=0, out_valid=0; in_ready=1 once in IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch inputs.
  - Non-shift op: compute result in the same edge, go to DONE.
  - SLL/SRL with op_b[SHAMT_W-1:0]==0: result=op_a, go to DONE.
  - SLL/SRL otherwise: load the shift register with op_a and the counter with the shamt, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: shift 1 bit (SLL left, zero fill; SRL logical right, zero fill) and decrement the counter.
  - When the counter reaches 1 and that final shift is applied, go to DONE.
- DONE:
  - out_valid=1; result, zero and branch_taken are stable and held while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops next cycle.
- Latency (accept edge = cycle N):
  - Non-shift: out_valid at N+1.
  - Shift by k>0: out_valid at N+1+k.
  - Minimum throughput: one operation per 2 cycles; in_ready is low in DONE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow output.
  - SLT is a signed compare; SLTU is unsigned. Both give a zero-extended 1 or 0.
  - Only op_b[SHAMT_W-1:0] is used as the shift amount; upper bits are ignored.
- zero is registered together with result (result==0).
- branch_taken, evaluated on the latched operands and registered with result; forced 0 when is_branch=0:
  - 000 eq
  - 001 ne
  - 010 always (JAL)
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 011 never
- in_valid while not in IDLE is ignored; the upstream stage must hold its operation until in_ready.
- Reset asserted during SHIFT or DONE: the pending operation is discarded and no out_valid is produced.
- Changing inputs after acceptance has no effect on the in-flight operation.

Test Plan:
- Reset mid-SHIFT (SLL, shamt 20; reset at cycle 5) -> out_valid never asserts; result=0; in_ready=1 after reset release.
- ADD 0x7FFFFFFF + 0x00000001 -> out_valid at N+1; result=0x80000000, zero=0. SUB 5-5 -> result=0, zero=1.
- SLL 0x00000001 by op_b=0x00000023 (shamt 3) -> out_valid at N+4, result=0x00000008. SRL 0x80000000 by 31 -> N+32, result=0x00000001. Shamt 0 -> N+1, result=op_a.
- SLT 0xFFFFFFFF vs 1 -> result=1. SLTU with the same operands -> result=0. Unknown op 1111 on 3+4 -> result=7.
- Branch, SUB with is_branch=1:
  - branch 000: a=b=0x10 -> taken=1.
  - branch 100: a=-1, b=0 -> taken=1.
  - branch 110: same operands -> taken=0.
  - branch 010 -> taken=1.
  - branch 011 -> taken=0.
  - is_branch=0 -> taken=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0. A second in_valid during this time is not accepted. Raise out_ready -> IDLE next cycle, then the second op is accepted.
